// File: rtl/mux_n_scan.sv
// N-channel registered multiplexer. In manual mode an external select picks the channel;
// in scan mode an internal counter visits every channel for DWELL enabled cycles each.
module mux_n_scan #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NCH*WIDTH-1:0]   i_d,
    input  logic [SEL_W-1:0]       i_sel,
    input  logic                   i_mode,
    input  logic                   i_en,
    output logic [WIDTH-1:0]       o_y,
    output logic [SEL_W-1:0]       o_ch,
    output logic                   o_valid,
    output logic                   o_sel_err,
    output logic                   o_wrap
);

    localparam int                DW_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W:0]    NCH_V   = (SEL_W + 1)'(NCH);
    localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(NCH - 1);
    localparam logic [DW_W-1:0]   LAST_DW = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAN,
        SCAN
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ch_cnt_q, ch_cnt_d;
    logic [DW_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic              valid_q, valid_d;
    logic              sel_err_q, sel_err_d;
    logic              wrap_q, wrap_d;

    logic [SEL_W-1:0]  idx;
    logic [WIDTH-1:0]  mux_y;
    logic              sel_oor;

    // Counters are zero whenever the state is not SCAN, so scan entry needs no special case.
    assign idx     = i_mode ? ch_cnt_q : i_sel;
    assign sel_oor = {1'b0, i_sel} >= NCH_V;

    always_comb begin
        mux_y = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == SEL_W'(k)) begin
                mux_y = i_d[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        ch_cnt_d    = ch_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        y_d         = y_q;
        ch_d        = ch_q;
        valid_d     = 1'b0;
        sel_err_d   = 1'b0;
        wrap_d      = 1'b0;

        if (i_en) begin
            if (i_mode) begin
                state_d = SCAN;
                y_d     = mux_y;
                ch_d    = ch_cnt_q;
                valid_d = 1'b1;
                // Counters at 0/0 while already scanning can only follow a wrap step.
                wrap_d  = (state_q == SCAN) && (ch_cnt_q == '0) && (dwell_cnt_q == '0);
                if (dwell_cnt_q == LAST_DW) begin
                    dwell_cnt_d = '0;
                    ch_cnt_d    = (ch_cnt_q == LAST_CH) ? '0 : ch_cnt_q + SEL_W'(1);
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DW_W'(1);
                end
            end else begin
                state_d     = MAN;
                ch_cnt_d    = '0;
                dwell_cnt_d = '0;
                if (sel_oor) begin
                    sel_err_d = 1'b1;
                end else begin
                    y_d     = mux_y;
                    ch_d    = i_sel;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            ch_cnt_q    <= '0;
            dwell_cnt_q <= '0;
            y_q         <= '0;
            ch_q        <= '0;
            valid_q     <= 1'b0;
            sel_err_q   <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            ch_cnt_q    <= ch_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            y_q         <= y_d;
            ch_q        <= ch_d;
            valid_q     <= valid_d;
            sel_err_q   <= sel_err_d;
            wrap_q      <= wrap_d;
        end
    end

    assign o_y       = y_q;
    assign o_ch      = ch_q;
    assign o_valid   = valid_q;
    assign o_sel_err = sel_err_q;
    assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_mux_n_scan.sv
// Scoreboard bench for mux_n_scan: a 4-channel DWELL=4 instance and a 3-channel instance
// for the out-of-range select, both fed from the same stimulus.
module tb_mux_n_scan;

    typedef struct {
        logic [7:0] y;
        logic [1:0] ch;
        logic       v;
        logic       e;
        logic       w;
        bit         d3;
        string      nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_d;
    logic [23:0] i_d3;
    logic [1:0]  i_sel;
    logic        i_mode;
    logic        i_en;

    logic [7:0]  y4, y3;
    logic [1:0]  ch4, ch3;
    logic        v4, v3, e4, e3, w4, w3;

    exp_t        sb[$];
    exp_t        mon_e;
    event        async_chk;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign i_d3 = i_d[23:0];

    mux_n_scan #(.WIDTH(8), .NCH(4), .SEL_W(2), .DWELL(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(i_d), .i_sel(i_sel), .i_mode(i_mode), .i_en(i_en),
        .o_y(y4), .o_ch(ch4), .o_valid(v4), .o_sel_err(e4), .o_wrap(w4)
    );

    mux_n_scan #(.WIDTH(8), .NCH(3), .SEL_W(2), .DWELL(4)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(i_d3), .i_sel(i_sel), .i_mode(i_mode), .i_en(i_en),
        .o_y(y3), .o_ch(ch3), .o_valid(v3), .o_sel_err(e3), .o_wrap(w3)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] ey, input logic [1:0] ech, input logic ev,
                            input logic ee, input logic ew, input bit d3, input string nm);
        exp_t e;
        e.y = ey; e.ch = ech; e.v = ev; e.e = ee; e.w = ew; e.d3 = d3; e.nm = nm;
        sb.push_back(e);
    endtask

    // Inputs change on the falling edge; the expectation is for the following rising edge.
    task automatic drive(input logic rst, input logic en, input logic mode, input logic [1:0] sel,
                         input logic [7:0] ey, input logic [1:0] ech, input logic ev,
                         input logic ee, input logic ew, input bit d3, input string nm);
        @(negedge clk);
        rst_n  = rst;
        i_en   = en;
        i_mode = mode;
        i_sel  = sel;
        push_exp(ey, ech, ev, ee, ew, d3, nm);
    endtask

    initial begin
        forever begin
            @(posedge clk or async_chk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                if (mon_e.d3) begin
                    check({mon_e.nm, ".y"},   32'(y3),  32'(mon_e.y));
                    check({mon_e.nm, ".ch"},  32'(ch3), 32'(mon_e.ch));
                    check({mon_e.nm, ".v"},   32'(v3),  32'(mon_e.v));
                    check({mon_e.nm, ".err"}, 32'(e3),  32'(mon_e.e));
                    check({mon_e.nm, ".wr"},  32'(w3),  32'(mon_e.w));
                end else begin
                    check({mon_e.nm, ".y"},   32'(y4),  32'(mon_e.y));
                    check({mon_e.nm, ".ch"},  32'(ch4), 32'(mon_e.ch));
                    check({mon_e.nm, ".v"},   32'(v4),  32'(mon_e.v));
                    check({mon_e.nm, ".err"}, 32'(e4),  32'(mon_e.e));
                    check({mon_e.nm, ".wr"},  32'(w4),  32'(mon_e.w));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] scan_ch [22];
        scan_ch = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                    2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};

        rst_n  = 1'b0;
        i_en   = 1'b0;
        i_mode = 1'b0;
        i_sel  = 2'd2;
        i_d    = 32'h1312_1110;

        for (int i = 0; i < 3; i++) drive(0, 0, 0, 2'd2, 8'h00, 2'd0, 0, 0, 0, 0, "reset");
        drive(1, 0, 0, 2'd2, 8'h00, 2'd0, 0, 0, 0, 0, "idle_dis");

        drive(1, 1, 0, 2'd2, 8'h12, 2'd2, 1, 0, 0, 0, "first_out");

        drive(1, 1, 0, 2'd1, 8'h11, 2'd1, 1, 0, 0, 1, "man3_sel1");
        drive(1, 1, 0, 2'd3, 8'h11, 2'd1, 0, 1, 0, 1, "man3_oor");
        drive(1, 0, 0, 2'd3, 8'h11, 2'd1, 0, 0, 0, 1, "man3_dis");

        for (int i = 0; i < 22; i++)
            drive(1, 1, 1, 2'd0, 8'h10 + {6'd0, scan_ch[i]}, scan_ch[i], 1, 0, (i == 16), 0, "scan");

        for (int i = 0; i < 5; i++) drive(1, 0, 1, 2'd0, 8'h11, 2'd1, 0, 0, 0, 0, "en_gap");
        drive(1, 1, 1, 2'd0, 8'h11, 2'd1, 1, 0, 0, 0, "resume_d2");
        drive(1, 1, 1, 2'd0, 8'h11, 2'd1, 1, 0, 0, 0, "resume_d3");
        drive(1, 1, 1, 2'd0, 8'h12, 2'd2, 1, 0, 0, 0, "resume_adv");

        drive(1, 1, 1, 2'd0, 8'h12, 2'd2, 1, 0, 0, 0, "pre_exp1");
        drive(1, 1, 1, 2'd0, 8'h12, 2'd2, 1, 0, 0, 0, "pre_exp2");
        drive(1, 0, 1, 2'd0, 8'h12, 2'd2, 0, 0, 0, 0, "exp_dis");
        drive(1, 1, 1, 2'd0, 8'h12, 2'd2, 1, 0, 0, 0, "exp_late");
        drive(1, 1, 1, 2'd0, 8'h13, 2'd3, 1, 0, 0, 0, "exp_adv");

        drive(1, 1, 0, 2'd1, 8'h11, 2'd1, 1, 0, 0, 0, "to_man");
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 2'd0, 8'h10, 2'd0, 1, 0, 0, 0, "rescan0");
        drive(1, 1, 1, 2'd0, 8'h11, 2'd1, 1, 0, 0, 0, "rescan1");

        drive(1, 0, 0, 2'd2, 8'h11, 2'd1, 0, 0, 0, 0, "mode_dis");
        drive(1, 1, 1, 2'd0, 8'h11, 2'd1, 1, 0, 0, 0, "mode_ign");
        drive(1, 1, 1, 2'd0, 8'h11, 2'd1, 1, 0, 0, 0, "walk1");
        drive(1, 1, 1, 2'd0, 8'h11, 2'd1, 1, 0, 0, 0, "walk1");
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 2'd0, 8'h12, 2'd2, 1, 0, 0, 0, "walk2");
        drive(1, 1, 1, 2'd0, 8'h13, 2'd3, 1, 0, 0, 0, "walk3");

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 push_exp(8'h00, 2'd0, 0, 0, 0, 0, "async_rst");
        -> async_chk;

        drive(0, 1, 1, 2'd0, 8'h00, 2'd0, 0, 0, 0, 0, "rst_held");
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 2'd0, 8'h10, 2'd0, 1, 0, 0, 0, "post_rst0");
        drive(1, 1, 1, 2'd0, 8'h11, 2'd1, 1, 0, 0, 0, "post_rst1");

        @(posedge clk);
        #2;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_n_scan.md
# mux_n_scan

Parametrised N-channel, W-bit registered multiplexer with two select modes. In manual mode the channel comes from an external select. In scan mode an internal counter steps through all channels, holding each one for a fixed dwell time. The block sits between the per-channel data sources and a single downstream consumer, such as a display or UART formatter, and replaces the fixed 4:1 combinational muxes used so far.

## Interface

Parameters:
- `WIDTH`, default 8: data width per channel.
- `NCH`, default 4: number of channels. Legal range is 2..16.
- `SEL_W`, default 2: select/index width. Must satisfy 2**SEL_W >= NCH.
- `DWELL`, default 16: cycles each channel is held in scan mode. Must be >= 1.

Ports (clock and reset first):
- `i_clk`, input, 1: single clock. All logic uses its rising edge.
- `i_rst_n`, input, 1: reset. Asynchronous assert, active-low.
- `i_d`, input, NCH*WIDTH: packed channel data. Channel k occupies bits [k*WIDTH +: WIDTH].
- `i_sel`, input, SEL_W: manual channel select.
- `i_mode`, input, 1: 0 selects manual mode, 1 selects scan mode.
- `i_en`, input, 1: enable. When low, all state holds.
- `o_y`, output, WIDTH: registered selected data.
- `o_ch`, output, SEL_W: index of the channel currently on `o_y`.
- `o_valid`, output, 1: `o_y`/`o_ch` were updated from live input this cycle.
- `o_sel_err`, output, 1: manual select was out of range (i_sel >= NCH).
- `o_wrap`, output, 1: one-cycle pulse when scan steps from channel NCH-1 back to 0.

Clock/reset decision: one clock; reset is asynchronous and active-low.

## Operation

State machine states:
- IDLE: the state after reset.
- MAN: manual mode.
- SCAN: scan mode.

Transitions, evaluated only when i_en=1:
- IDLE goes to MAN if i_mode=0, or to SCAN if i_mode=1.
- MAN goes to SCAN when i_mode=1.
- SCAN goes to MAN when i_mode=0.

When i_en=0:
- State, counters, `o_y` and `o_ch` hold.
- `o_valid`, `o_sel_err` and `o_wrap` are driven 0.

MAN behaviour:
- Each enabled cycle, `o_y` <= channel i_sel and `o_ch` <= i_sel.
- If i_sel >= NCH: `o_y`/`o_ch` hold, `o_sel_err`=1, `o_valid`=0.

SCAN behaviour:
- Internal registers are `ch_cnt` (0..NCH-1) and `dwell_cnt` (0..DWELL-1).
- Each enabled cycle, `o_y` <= channel ch_cnt and `o_ch` <= ch_cnt.
- When dwell_cnt = DWELL-1: dwell_cnt <= 0, and ch_cnt advances by one, wrapping NCH-1 -> 0.
- Otherwise dwell_cnt increments.
- The wrap step raises `o_wrap` for one cycle.
- With DWELL=1, the channel advances every enabled cycle.

Mode entry rules:
- Entering SCAN from IDLE or MAN clears ch_cnt and dwell_cnt, so the first scanned channel is 0 with a full dwell.
- Entering MAN uses i_sel from the same cycle.
- The counters are not preserved across a round trip through MAN.

Data rules:
- Data is passed unmodified; there is no arithmetic on data.
- Counters are SEL_W and clog2(DWELL)-sized.
- The out-of-range check compares the full i_sel against NCH.

## Timing

- Reset values: o_y=0, o_ch=0, o_valid=0, o_sel_err=0, o_wrap=0, state=IDLE, ch_cnt=0, dwell_cnt=0.
- Latency is 1 cycle. Inputs sampled on edge t appear on outputs after edge t, i.e. during cycle t+1.
- The first enabled cycle after IDLE already produces valid output: o_valid=1 at t+1. This applies in both modes.
- Mode switch on edge t: output after t comes from the new mode. In SCAN this is channel 0.
- Asserting `i_rst_n` low mid-scan forces all outputs and state to their reset values immediately, without waiting for a clock edge.
- Release of reset is synchronous to `i_clk`.
- If i_en falls on the same edge as a dwell expiry, the advance does not occur. It happens on the next enabled DWELL-1 edge.
- If a mode change and i_en=0 occur together, the mode change is ignored until i_en=1.
- `o_wrap` and `o_valid` are both 1 on the wrap cycle.

## Test plan

- **Reset and first output.** Reset, then i_en=1, i_mode=0, i_sel=2, i_d channel k = 8'h10+k. Required: o_y=8'h12, o_ch=2, o_valid=1 one cycle after the first enabled edge. All outputs are 0 during reset.
- **Manual out-of-range select.** NCH=3, SEL_W=2, i_sel=3. Required: o_sel_err=1, o_valid=0, and o_y/o_ch keep their previous values (8'h11/1 from a prior i_sel=1).
- **Scan sequence.** DWELL=4, NCH=4, i_mode=1 held for 20 cycles. Required: o_ch follows 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0. o_wrap=1 only on the 3->0 step.
- **Enable gating mid-dwell.** In scan, drop i_en for 5 cycles at dwell_cnt=2. Required: o_y/o_ch hold and o_valid=0 while disabled. After re-enable, the channel advances after exactly 2 more enabled cycles (DWELL-2 remaining).
- **Mode switch restart.** Scan reaches ch 2, switch to manual with i_sel=1, then back to scan. Required: o_ch reads 2 -> 1 -> 0, and the scan restarts at 0 with a full dwell.
- **Asynchronous reset mid-scan.** Pulse i_rst_n low between clock edges while o_ch=3. Required: o_y=0, o_ch=0, o_valid=0 before the next edge. After release with i_en=1, i_mode=1, output restarts at channel 0.
